// File: rtl/cfg_uart_pkg.sv
// cfg_uart_pkg: shared FSM state types and protocol constants for the
// configuration UART (cfg_uart and its byte receiver).
package cfg_uart_pkg;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  localparam int          CMD_BYTES = 3;
  localparam int          RSP_BYTES = 2;
  localparam logic [15:0] POSACK    = 16'h0A5A;
  localparam logic [15:0] NEGACK    = 16'h05A5;

endpackage

// File: rtl/cfg_uart_if.sv
// cfg_uart_if: parallel command/response handshake between the config UART
// (slave) and the controller that consumes frames and issues responses
// (master).
interface cfg_uart_if;
  logic [23:0] cmd_data;
  logic        frm_rdy;
  logic        clr_frm_rdy;
  logic [15:0] tx_data;
  logic        strt_tx;
  logic        tx_busy;
  logic        tx_done;

  modport slave (
    output cmd_data, frm_rdy, tx_busy, tx_done,
    input  clr_frm_rdy, tx_data, strt_tx
  );

  modport master (
    input  cmd_data, frm_rdy, tx_busy, tx_done,
    output clr_frm_rdy, tx_data, strt_tx
  );
endinterface

// File: rtl/cfg_uart_rx_byte.sv
// cfg_uart_rx_byte: 8N1 byte receiver. Synchronizes the serial line, finds
// start edges, samples each bit at mid-bit and flags a good byte (byte_rdy)
// or a low stop bit (frm_err) for one cycle at the stop sample.
module cfg_uart_rx_byte
  import cfg_uart_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic [7:0] rx_byte,
  output logic       byte_rdy,
  output logic       frm_err,
  output logic       rx_idle
);

  localparam int               CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF  = CNT_W'(BAUD_DIV / 2 - 1);

  logic             rx_s1_reg, rx_s2_reg, rx_prev_reg;
  logic             fall_edge;
  rx_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       bit_reg, bit_next;
  logic [7:0]       shift_reg, shift_next;

  // Two-flop synchronizer plus a history flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_reg   <= 1'b1;
      rx_s2_reg   <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_s1_reg   <= rx_in;
      rx_s2_reg   <= rx_s1_reg;
      rx_prev_reg <= rx_s2_reg;
    end
  end

  assign fall_edge = rx_prev_reg & ~rx_s2_reg;

  // Receive FSM state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RX_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
    end
  end

  // Next-state logic: half a bit to the start sample, then one bit-time per
  // data bit and one more to the stop sample.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    byte_rdy   = 1'b0;
    frm_err    = 1'b0;
    unique case (state_reg)
      RX_IDLE: begin
        if (fall_edge) begin
          state_next = RX_START;
          cnt_next   = '0;
        end
      end
      RX_START: begin
        if (cnt_reg == HALF) begin
          cnt_next   = '0;
          bit_next   = '0;
          // A line that is high again at mid-start was only a glitch.
          state_next = rx_s2_reg ? RX_IDLE : RX_DATA;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_reg == LAST) begin
          cnt_next   = '0;
          shift_next = {rx_s2_reg, shift_reg[7:1]};
          if (bit_reg == 3'd7) begin
            state_next = RX_STOP;
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_reg == LAST) begin
          cnt_next   = '0;
          state_next = RX_IDLE;
          byte_rdy   = rx_s2_reg;
          frm_err    = ~rx_s2_reg;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = RX_IDLE;
    endcase
  end

  assign rx_byte = shift_reg;
  assign rx_idle = (state_reg == RX_IDLE);

endmodule

// File: rtl/cfg_uart.sv
// cfg_uart: configuration UART. Assembles three received bytes into a
// 24-bit command frame and serializes a 16-bit response (high byte first).
// Optional build macro CFG_UART_TIMEOUT_EN: drop a partial frame after
// TIMEOUT_BITS idle bit-times between its bytes.
module cfg_uart
  import cfg_uart_pkg::*;
#(
  parameter int BAUD_DIV     = 434,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     RX_C,
  output logic     TX_C,
  cfg_uart_if.slave ctl
);

  localparam int               CNT_W     = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] LAST      = CNT_W'(BAUD_DIV - 1);
  localparam logic [1:0]       LAST_BYTE = 2'(CMD_BYTES - 1);
  localparam logic             LAST_RSP  = 1'(RSP_BYTES - 1);

  // ---------------- receive path ----------------
  logic [7:0]  rx_data;
  logic        byte_rdy, frm_err, rx_idle;
  logic [1:0]  byte_cnt_reg;
  logic [15:0] asm_reg;
  logic [23:0] cmd_data_reg;
  logic        frm_rdy_reg;
  logic        frame_done;
  logic        to_hit;

  cfg_uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_in    (RX_C),
    .rx_byte  (rx_data),
    .byte_rdy (byte_rdy),
    .frm_err  (frm_err),
    .rx_idle  (rx_idle)
  );

`ifdef CFG_UART_TIMEOUT_EN
  localparam int TO_CYCLES = TIMEOUT_BITS * BAUD_DIV;
  localparam int TO_W      = $clog2(TO_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_reg;

  assign to_hit = (to_cnt_reg == TO_W'(TO_CYCLES - 1));

  // Idle timer: runs only while a partial frame waits for its next byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_reg <= '0;
    end else if (byte_cnt_reg == 2'd0 || !rx_idle || byte_rdy) begin
      to_cnt_reg <= '0;
    end else if (!to_hit) begin
      to_cnt_reg <= to_cnt_reg + TO_W'(1);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = rx_idle ^ (TIMEOUT_BITS == 0);
  assign to_hit         = 1'b0;
`endif

  assign frame_done = byte_rdy && (byte_cnt_reg == LAST_BYTE);

  // Frame assembly: the first two bytes wait in asm_reg, the third one
  // publishes the whole frame; a framing error or timeout restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_reg <= '0;
      asm_reg      <= '0;
      cmd_data_reg <= '0;
    end else if (byte_rdy) begin
      asm_reg <= {asm_reg[7:0], rx_data};
      if (byte_cnt_reg == LAST_BYTE) begin
        cmd_data_reg <= {asm_reg, rx_data};
        byte_cnt_reg <= '0;
      end else begin
        byte_cnt_reg <= byte_cnt_reg + 2'd1;
      end
    end else if (frm_err || to_hit) begin
      byte_cnt_reg <= '0;
    end
  end

  // Frame-ready flag: a completing frame beats a same-cycle acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_rdy_reg <= 1'b0;
    end else if (frame_done) begin
      frm_rdy_reg <= 1'b1;
    end else if (ctl.clr_frm_rdy) begin
      frm_rdy_reg <= 1'b0;
    end
  end

  assign ctl.cmd_data = cmd_data_reg;
  assign ctl.frm_rdy  = frm_rdy_reg;

  // ---------------- transmit path ----------------
  tx_state_t        tx_state_reg, tx_state_next;
  logic [CNT_W-1:0] tx_cnt_reg, tx_cnt_next;
  logic [2:0]       tx_bit_reg, tx_bit_next;
  logic             tx_idx_reg, tx_idx_next;
  logic [15:0]      tx_word_reg, tx_word_next;
  logic             tx_line_reg, tx_line_next;
  logic [7:0]       tx_byte_sel;
  logic             tx_fin;

  // Transmit FSM state and datapath registers; the serial line is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_reg <= TX_IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_idx_reg   <= 1'b0;
      tx_word_reg  <= '0;
      tx_line_reg  <= 1'b1;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_cnt_reg   <= tx_cnt_next;
      tx_bit_reg   <= tx_bit_next;
      tx_idx_reg   <= tx_idx_next;
      tx_word_reg  <= tx_word_next;
      tx_line_reg  <= tx_line_next;
    end
  end

  // Next-state logic: two back-to-back 10-bit characters, then done.
  always_comb begin
    tx_state_next = tx_state_reg;
    tx_cnt_next   = tx_cnt_reg;
    tx_bit_next   = tx_bit_reg;
    tx_idx_next   = tx_idx_reg;
    tx_word_next  = tx_word_reg;
    tx_fin        = 1'b0;
    tx_byte_sel   = 8'h00;
    tx_line_next  = 1'b1;
    unique case (tx_state_reg)
      TX_IDLE: begin
        if (ctl.strt_tx) begin
          tx_word_next  = ctl.tx_data;
          tx_state_next = TX_START;
          tx_cnt_next   = '0;
          tx_idx_next   = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_reg == LAST) begin
          tx_cnt_next   = '0;
          tx_bit_next   = '0;
          tx_state_next = TX_DATA;
        end else begin
          tx_cnt_next = tx_cnt_reg + CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_reg == LAST) begin
          tx_cnt_next = '0;
          if (tx_bit_reg == 3'd7) begin
            tx_state_next = TX_STOP;
          end else begin
            tx_bit_next = tx_bit_reg + 3'd1;
          end
        end else begin
          tx_cnt_next = tx_cnt_reg + CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt_reg == LAST) begin
          tx_cnt_next = '0;
          if (tx_idx_reg == LAST_RSP) begin
            tx_state_next = TX_IDLE;
            tx_fin        = 1'b1;
          end else begin
            tx_idx_next   = 1'b1;
            tx_state_next = TX_START;
          end
        end else begin
          tx_cnt_next = tx_cnt_reg + CNT_W'(1);
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase

    // Line level follows the state being entered, so it is registered
    // in lockstep with the FSM.
    tx_byte_sel = tx_idx_next ? tx_word_next[7:0] : tx_word_next[15:8];
    unique case (tx_state_next)
      TX_START: tx_line_next = 1'b0;
      TX_DATA:  tx_line_next = tx_byte_sel[tx_bit_next];
      default:  tx_line_next = 1'b1;
    endcase
  end

  assign TX_C        = tx_line_reg;
  assign ctl.tx_done = tx_fin;
  assign ctl.tx_busy = (tx_state_reg != TX_IDLE) && !tx_fin;

endmodule
